// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, jump field width, PC source encoding
// and the fetch sequencer state.
package cpu_types_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned ADDR_W        = 26;
    localparam int unsigned PC_STEP_BYTES = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] jaddr_t;

    // Values match the redir_src encoding of the branch-resolution logic.
    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_J   = 2'b10,
        PC_JR  = 2'b11
    } pc_src_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fseq_state_t;

    // A redirect with source PC_SEQ carries no target and is ignored.
    function automatic logic is_redirect(input logic valid, input logic [1:0] src);
        return valid && (pc_src_t'(src) != PC_SEQ);
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect-target calculation for branch, jump and JR.
module pc_target_calc
    import cpu_types_pkg::*;
(
    input  logic [1:0] i_src,
    input  word_t      i_base,
    input  word_t      i_imm16,
    input  jaddr_t     i_imm26,
    input  word_t      i_regval,
    output word_t      o_target
);

    word_t w_br_target;
    word_t w_j_target;

    // Branch offsets are in words; the adder wraps modulo 2^32.
    assign w_br_target = i_base + {i_imm16[WORD_W-3:0], 2'b00};
    assign w_j_target  = {i_base[WORD_W-1:WORD_W-4], i_imm26, 2'b00};

    // NOTE: assign o_target before the case so no path leaves it unassigned,
    // otherwise synthesis infers a latch.
    always_comb begin
        o_target = i_base;
        unique case (pc_src_t'(i_src))
            PC_BR:   o_target = w_br_target;
            PC_J:    o_target = w_j_target;
            PC_JR:   o_target = i_regval;
            default: o_target = i_base;
        endcase
    end

    logic w_unused;
    assign w_unused = ^i_imm16[WORD_W-1:WORD_W-2];

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage controller: owns the PC, holds the imem address across wait
// states, defers mid-request redirects, and handles stall, flush and halt.
module pc_fetch_sequencer
    import cpu_types_pkg::*;
#(
    parameter word_t       RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = PC_STEP_BYTES
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ihit,
    input  logic       stall,
    input  logic       redir_valid,
    input  logic [1:0] redir_src,
    input  word_t      redir_base,
    input  word_t      imm16,
    input  jaddr_t     imm26,
    input  word_t      regval,
    input  logic       halt,
    output logic       iREN,
    output word_t      imemaddr,
    output logic       fetch_valid,
    output logic       flush,
    output logic       halted
);

    fseq_state_t r_state;
    word_t       r_pc;
    logic        r_pend_valid;
    word_t       r_pend_pc;

    word_t       w_target;
    logic        w_redir;
    logic        w_run;

    pc_target_calc u_target (
        .i_src    (redir_src),
        .i_base   (redir_base),
        .i_imm16  (imm16),
        .i_imm26  (imm26),
        .i_regval (regval),
        .o_target (w_target)
    );

    assign w_run   = (r_state == RUN);
    assign w_redir = is_redirect(redir_valid, redir_src);

    // The PC only moves on an ihit edge, so imemaddr is stable while a
    // request is outstanding; redirects without ihit park in r_pend_pc.
    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= RUN;
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= RESET_PC;
        end else if (r_state == RUN) begin
            if (halt) begin
                r_state      <= HALTED;
                r_pend_valid <= 1'b0;
            end else if (w_redir) begin
                if (ihit) begin
                    r_pc         <= w_target;
                    r_pend_valid <= 1'b0;
                end else begin
                    r_pend_pc    <= w_target;
                    r_pend_valid <= 1'b1;
                end
            end else if (ihit) begin
                if (r_pend_valid) begin
                    r_pc         <= r_pend_pc;
                    r_pend_valid <= 1'b0;
                end else if (!stall) begin
                    r_pc <= r_pc + word_t'(PC_STEP);
                end
            end
        end
    end

    assign iREN        = w_run;
    assign halted      = !w_run;
    assign imemaddr    = r_pc;
    assign flush       = w_run && (w_redir || halt);
    assign fetch_valid = w_run && ihit && !stall && !w_redir && !r_pend_valid && !halt;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Fetch-stage controller that owns the program counter register and sequences instruction fetch against instruction memory. It chooses the next PC from sequential increment, branch, jump or jump-register targets. It holds the fetch address stable across memory wait states and defers redirects that arrive mid-request. It also handles pipeline stalls, flushes and halt. It sits between the hazard/branch-resolution logic and the imem request port of each core.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, sequential increment in bytes.

Ports:
CLK  input  1  core clock
RST  input  1  synchronous active-high reset
ihit  input  1  imem returned the instruction at imemaddr this cycle
stall  input  1  hazard unit freezes IF/ID; hold the sequential advance
redir_valid  input  1  control-flow redirect resolved this cycle
redir_src  input  2  01 branch, 10 jump (J/JAL), 11 JR; 00 is ignored (treated as no redirect)
redir_base  input  32 (word_t)  PC+4 of the redirecting instruction
imm16  input  32 (word_t)  sign-extended branch word offset
imm26  input  ADDR_W  jump target field
regval  input  32 (word_t)  JR register value
halt  input  1  HALT reached writeback
iREN  output  1  imem read enable
imemaddr  output  32 (word_t)  fetch address (= PC register)
fetch_valid  output  1  fetched word is on the correct path; IF/ID must capture it
flush  output  1  squash IF/ID contents this cycle
halted  output  1  sequencer is in HALTED

Behaviour:
- Reset (RST=1 at a CLK edge, from any state): PC=RESET_PC, pend_valid=0, state=RUN.
- Reset output values: iREN=1, imemaddr=RESET_PC, fetch_valid=0, flush=0, halted=0.
- States: RUN (fetching) and HALTED. The pending-redirect register (pend_valid, pend_pc) is orthogonal to state.
- Target calculation (combinational, 32-bit, overflow wraps mod 2^32):
  - branch: redir_base + (imm16 << 2)
  - jump: {redir_base[31:28], imm26, 2'b00}
  - JR: regval unmodified.
- Address stability: imemaddr changes only on an edge where ihit=1, or on reset. It never changes while a request is outstanding.
- RUN priority per cycle: halt > redirect > stall > sequential.
  - halt=1: next state HALTED. PC is held, pend_valid is cleared, fetch_valid=0, flush=1.
  - redir_valid=1 and ihit=1: PC <= target. Any pending target is discarded. fetch_valid=0, flush=1. Redirect overrides stall.
  - redir_valid=1 and ihit=0: pend_pc <= target, pend_valid <= 1, flush=1. PC is held. A newer redirect overwrites an older pending one.
  - pend_valid=1, ihit=1, no new redirect: PC <= pend_pc, pend_valid <= 0, fetch_valid=0. The returned word is wrong-path and is dropped.
  - stall=1, ihit=1, no redirect/pending: PC is held, fetch_valid=0. iREN stays 1 and the fetch is reissued.
  - ihit=1, no stall/redirect/pending: PC <= PC + PC_STEP, fetch_valid=1.
  - ihit=0 with no redirect: PC is held, fetch_valid=0.
- fetch_valid is combinational: ihit & ~stall & ~redir_valid & ~pend_valid & ~halt & (state==RUN).
- flush is combinational: (redir_valid | halt) & (state==RUN).
- HALTED:
  - Outputs: iREN=0, fetch_valid=0, flush=0, halted=1.
  - PC is frozen. All inputs except RST are ignored. Only RST exits this state.
- No extra latency: a redirect resolved together with ihit fetches the target in the next cycle.

Decomposition:
- cpu_types_pkg additions:
  - pc_src_t enum {PC_SEQ, PC_BR, PC_J, PC_JR}, 2 bits, matching the redir_src encoding.
  - typedef fseq_state_t {RUN, HALTED}.
  - PC_STEP shared as a constant.
- ADDR_W and word_t are reused from the package.
- One sub-module, pc_target_calc: the purely combinational target mux/adder (redir_src, redir_base, imm16, imm26, regval -> target).
- The sequencer itself holds the PC, the pending register and the FSM.
- Ports are bundled on the existing pc interface extended with fetch-control signals, under a new modport fseq.

Test Plan:
- Reset + sequential: RST 1 cycle, ihit=1 constant -> imemaddr 0,4,8,C on consecutive cycles; fetch_valid=1 from cycle 1.
- Wait states: ihit low 3 cycles at PC=8 -> imemaddr stays 8, fetch_valid=0; when ihit=1 -> next imemaddr=C.
- Branch with hit: redir_src=01, base=0x10, imm16=0xFFFF_FFFC, ihit=1 -> flush=1, fetch_valid=0, next imemaddr=0x0000_0000.
- Deferred JR: regval=0x40 with ihit=0 -> imemaddr held. Then jump imm26=0x10 at base=0x2000_0000 before the hit -> at ihit imemaddr becomes 0x2000_0040 (newest wins), that word is dropped (fetch_valid=0).
- Stall vs redirect: stall=1 with ihit=1 -> PC held 2 cycles. Then stall=1 plus jump to 0x100 -> imemaddr=0x100 next cycle.
- Halt: halt=1 at PC=0x20 with pending redirect -> halted=1, iREN=0, imemaddr stays 0x20 for 10 cycles. RST -> imemaddr=0, iREN=1.
